// File: rtl/regfile_scoreboard.sv
// Decode-stage register file with per-register scoreboard.
// NUM_READ combinational read ports, one synchronous writeback port, optional
// same-cycle write-to-read bypass and optional hardwired zero register.
module regfile_scoreboard #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned NUM_READ   = 2,
  parameter bit          ZERO_REG   = 1'b1,
  parameter bit          BYPASS     = 1'b1
) (
  input  logic                           i_Clk,
  input  logic                           i_Rst,
  input  logic [NUM_READ*ADDR_WIDTH-1:0] i_RdAddr,
  output logic [NUM_READ*DATA_WIDTH-1:0] o_RdData,
  output logic [NUM_READ-1:0]            o_RdBusy,
  input  logic                           i_WrEn,
  input  logic [ADDR_WIDTH-1:0]          i_WrAddr,
  input  logic [DATA_WIDTH-1:0]          i_WrData,
  input  logic                           i_IssueEn,
  input  logic [ADDR_WIDTH-1:0]          i_IssueAddr,
  output logic [2**ADDR_WIDTH-1:0]       o_BusyVec
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0]      busy;
  logic [DEPTH-1:0]      busy_nxt;
  logic                  wr_ok;
  logic                  iss_ok;

  // Register 0 swallows writes and issues when hardwired to zero.
  assign wr_ok  = i_WrEn    && !(ZERO_REG && (i_WrAddr    == '0));
  assign iss_ok = i_IssueEn && !(ZERO_REG && (i_IssueAddr == '0));

  // Scoreboard update: writeback clears, issue sets; issue applied last so a
  // newer producer on the same address keeps the register pending.
  always_comb begin
    busy_nxt = busy;
    if (wr_ok)  busy_nxt[i_WrAddr]    = 1'b0;
    if (iss_ok) busy_nxt[i_IssueAddr] = 1'b1;
  end

  // Storage and scoreboard state, cleared asynchronously.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
    end else begin
      if (wr_ok) regs[i_WrAddr] <= i_WrData;
      busy <= busy_nxt;
    end
  end

  assign o_BusyVec = busy;

  // Independent read ports: zero register, then bypass, then stored state.
  always_comb begin
    logic [ADDR_WIDTH-1:0] a;
    a        = '0;
    o_RdData = '0;
    o_RdBusy = '0;
    for (int k = 0; k < int'(NUM_READ); k++) begin
      a = i_RdAddr[k*ADDR_WIDTH +: ADDR_WIDTH];
      if (ZERO_REG && (a == '0)) begin
        o_RdData[k*DATA_WIDTH +: DATA_WIDTH] = '0;
        o_RdBusy[k]                          = 1'b0;
      end else if (BYPASS && i_WrEn && (i_WrAddr == a)) begin
        o_RdData[k*DATA_WIDTH +: DATA_WIDTH] = i_WrData;
        o_RdBusy[k]                          = 1'b0;
      end else begin
        o_RdData[k*DATA_WIDTH +: DATA_WIDTH] = regs[a];
        o_RdBusy[k]                          = busy[a];
      end
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: two instances (zero reg + bypass on, and both
// off) driven by shared stimulus and checked against an array-based model.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rst;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        iss_en;
  logic [4:0]  iss_addr;

  logic [63:0] rd_data_o  [2];
  logic [1:0]  rd_busy_o  [2];
  logic [31:0] busy_vec_o [2];

  int tests;
  int fails;

  // Model state per instance: instance 0 has ZERO_REG=1,BYPASS=1; instance 1 has both 0.
  logic [31:0] m_reg  [2][32];
  logic        m_busy [2][32];

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
                       .ZERO_REG(1'b1), .BYPASS(1'b1)) dut_a (
    .i_Clk(clk), .i_Rst(rst), .i_RdAddr(rd_addr),
    .o_RdData(rd_data_o[0]), .o_RdBusy(rd_busy_o[0]),
    .i_WrEn(wr_en), .i_WrAddr(wr_addr), .i_WrData(wr_data),
    .i_IssueEn(iss_en), .i_IssueAddr(iss_addr), .o_BusyVec(busy_vec_o[0]));

  regfile_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .NUM_READ(2),
                       .ZERO_REG(1'b0), .BYPASS(1'b0)) dut_b (
    .i_Clk(clk), .i_Rst(rst), .i_RdAddr(rd_addr),
    .o_RdData(rd_data_o[1]), .o_RdBusy(rd_busy_o[1]),
    .i_WrEn(wr_en), .i_WrAddr(wr_addr), .i_WrData(wr_data),
    .i_IssueEn(iss_en), .i_IssueAddr(iss_addr), .o_BusyVec(busy_vec_o[1]));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic bit is_zero(int inst, logic [4:0] a);
    return (inst == 0) && (a == 5'd0);
  endfunction

  function automatic logic [31:0] exp_data(int inst, logic [4:0] a);
    if (is_zero(inst, a)) return 32'h0;
    if (inst == 0 && wr_en && wr_addr == a) return wr_data;
    return m_reg[inst][a];
  endfunction

  function automatic logic exp_busy(int inst, logic [4:0] a);
    if (is_zero(inst, a)) return 1'b0;
    if (inst == 0 && wr_en && wr_addr == a) return 1'b0;
    return m_busy[inst][a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 2; i++)
      for (int r = 0; r < 32; r++) begin
        m_reg[i][r]  = 32'h0;
        m_busy[i][r] = 1'b0;
      end
  endtask

  task automatic cmp(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Full comparison of both instances against the model.
  task automatic check_all();
    logic [31:0] bv;
    logic [4:0]  a;
    for (int i = 0; i < 2; i++) begin
      for (int k = 0; k < 2; k++) begin
        a = rd_addr[k*5 +: 5];
        cmp($sformatf("inst%0d port%0d data a=%0d", i, k, a),
            rd_data_o[i][k*32 +: 32], exp_data(i, a));
        cmp($sformatf("inst%0d port%0d busy a=%0d", i, k, a),
            32'(rd_busy_o[i][k]), 32'(exp_busy(i, a)));
      end
      bv = '0;
      for (int r = 0; r < 32; r++) bv[r] = m_busy[i][r];
      cmp($sformatf("inst%0d busy_vec", i), busy_vec_o[i], bv);
    end
  endtask

  task automatic drive(logic we, logic [4:0] wa, logic [31:0] wd,
                       logic ie, logic [4:0] ia, logic [4:0] r0, logic [4:0] r1);
    wr_en = we; wr_addr = wa; wr_data = wd;
    iss_en = ie; iss_addr = ia;
    rd_addr = {r1, r0};
    #1;
    check_all();
  endtask

  // Advance one clock and apply the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        if (wr_en && !is_zero(i, wr_addr)) begin
          m_reg[i][wr_addr]  = wr_data;
          m_busy[i][wr_addr] = 1'b0;
        end
        if (iss_en && !is_zero(i, iss_addr)) m_busy[i][iss_addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  // Reset pulse asserted between edges, with whatever inputs are being driven.
  task automatic do_reset();
    rst = 1'b1;
    model_clear();
    #1;
    check_all();
    tick();
    rst = 1'b0;
    #1;
    check_all();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_en = 1'b0; iss_addr = '0; rd_addr = '0;
    model_clear();
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // Reset clears data and scoreboard without an edge.
    drive(1, 5, 32'hDEADBEEF, 1, 7, 5, 7); tick();
    drive(0, 0, 0, 0, 0, 5, 7);
    cmp("pre-reset r5", rd_data_o[0][31:0], 32'hDEADBEEF);
    cmp("pre-reset busy7", 32'(rd_busy_o[0][1]), 32'h1);
    rst = 1'b1;
    model_clear();
    #1;
    cmp("reset r5", rd_data_o[0][31:0], 32'h0);
    cmp("reset busy_vec", busy_vec_o[0], 32'h0);
    check_all();
    tick();
    rst = 1'b0;

    // Write then read on both ports.
    drive(1, 3, 32'h12345678, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 3, 3);
    cmp("rd r3 port0", rd_data_o[0][31:0], 32'h12345678);
    cmp("rd r3 port1", rd_data_o[0][63:32], 32'h12345678);
    cmp("rd r3 busy", 32'(rd_busy_o[0]), 32'h0);
    tick();

    // Bypass vs. pre-edge contents.
    drive(1, 9, 32'h11111111, 0, 0, 0, 0); tick();
    drive(1, 9, 32'hCAFEF00D, 0, 0, 0, 9);
    cmp("bypass r9", rd_data_o[0][63:32], 32'hCAFEF00D);
    cmp("no-bypass r9", rd_data_o[1][63:32], 32'h11111111);
    tick();

    // Zero register.
    drive(1, 0, 32'hFFFFFFFF, 1, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 0);
    cmp("zero r0", rd_data_o[0][31:0], 32'h0);
    cmp("zero r0 busy", 32'(rd_busy_o[0][0]), 32'h0);
    cmp("zero busy_vec0", 32'(busy_vec_o[0][0]), 32'h0);
    cmp("nonzero r0", rd_data_o[1][31:0], 32'hFFFFFFFF);
    cmp("nonzero busy_vec0", 32'(busy_vec_o[1][0]), 32'h1);
    tick();

    // Scoreboard: issue, observe pending, writeback clears.
    drive(0, 0, 0, 1, 4, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 4, 0);
    cmp("sb r4 busy", 32'(rd_busy_o[0][0]), 32'h1);
    tick();
    drive(1, 4, 32'h000000A5, 0, 0, 4, 0);
    cmp("sb r4 bypass data", rd_data_o[0][31:0], 32'h000000A5);
    cmp("sb r4 bypass busy", 32'(rd_busy_o[0][0]), 32'h0);
    cmp("sb r4 nobypass busy", 32'(rd_busy_o[1][0]), 32'h1);
    tick();

    // Simultaneous issue/write on same and different addresses.
    drive(1, 6, 32'h00000066, 1, 6, 6, 0); tick();
    drive(0, 0, 0, 1, 8, 6, 0);
    cmp("sim r6 busy", 32'(busy_vec_o[0][6]), 32'h1);
    cmp("sim r6 data", rd_data_o[0][31:0], 32'h00000066);
    tick();
    drive(1, 8, 32'h00000088, 1, 2, 2, 8); tick();
    drive(0, 0, 0, 0, 0, 2, 8);
    cmp("sim busy2", 32'(busy_vec_o[0][2]), 32'h1);
    cmp("sim busy8", 32'(busy_vec_o[0][8]), 32'h0);
    cmp("sim r8 data", rd_data_o[0][63:32], 32'h00000088);
    tick();

    // Randomized traffic with collisions and occasional mid-run resets.
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] wa, ia, r0, r1;
      bit narrow;
      narrow = ($urandom_range(0, 1) == 1);
      wa = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      ia = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r0 = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom);
      r1 = ($urandom_range(0, 3) == 0) ? r0 : (narrow ? 5'($urandom_range(0, 7)) : 5'($urandom));
      drive(1'($urandom), wa, $urandom, 1'($urandom), ia, r0, r1);
      if ($urandom_range(0, 199) == 0) do_reset();
      else tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised register file for the pipelined datapath, in the decode stage. It provides NUM_READ combinational read ports and one synchronous write port fed from writeback, with optional same-cycle write-to-read bypass and an optional hardwired zero register. A per-register scoreboard marks destinations of issued instructions as pending until their writeback lands, so decode can detect read-after-write hazards without a separate hazard table.

## Interface
Parameters:
- DATA_WIDTH, 32, register width in bits
- ADDR_WIDTH, 5, register address width; depth is 2**ADDR_WIDTH
- NUM_READ, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy
- BYPASS, 1, when 1, a same-cycle write is forwarded to matching read ports

Ports:
- i_Clk  in  1  clock; all state updates on the rising edge
- i_Rst  in  1  asynchronous, active-high reset
- i_RdAddr  in  NUM_READ*ADDR_WIDTH  packed read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- o_RdData  out  NUM_READ*DATA_WIDTH  packed read data; port k uses bits [k*DATA_WIDTH +: DATA_WIDTH]
- o_RdBusy  out  NUM_READ  scoreboard pending flag for each read address
- i_WrEn  in  1  write strobe from writeback
- i_WrAddr  in  ADDR_WIDTH  write address
- i_WrData  in  DATA_WIDTH  write data
- i_IssueEn  in  1  marks i_IssueAddr pending (an instruction with this destination has issued)
- i_IssueAddr  in  ADDR_WIDTH  destination of the issuing instruction
- o_BusyVec  out  2**ADDR_WIDTH  raw scoreboard bits, bit n = register n pending

## Operation
- Storage: 2**ADDR_WIDTH x DATA_WIDTH registers, plus a busy bit per register.
- Write: on a rising edge with i_WrEn=1, reg[i_WrAddr] <= i_WrData and busy[i_WrAddr] <= 0.
  - Exception: if ZERO_REG=1 and i_WrAddr=0, the write is dropped.
- Issue: on a rising edge with i_IssueEn=1, busy[i_IssueAddr] <= 1.
  - Exception: if ZERO_REG=1 and i_IssueAddr=0, the issue is ignored.
- Issue and write to the same address in the same cycle:
  - The data write happens.
  - The busy bit ends at 1, because the issue belongs to a newer producer.
- Issue and write to different addresses in the same cycle: both take effect independently.
- Write to a register whose busy bit is already 0: legal; data updates and busy stays 0.
- Read port k, with address a = i_RdAddr slice k (combinational):
  - ZERO_REG=1 and a=0: o_RdData slice k = 0 and o_RdBusy[k] = 0.
  - Otherwise, if BYPASS=1, i_WrEn=1 and i_WrAddr=a: the slice is i_WrData and o_RdBusy[k] = 0.
  - Otherwise: the slice is reg[a] and o_RdBusy[k] = busy[a].
- An issue in the current cycle does not affect o_RdBusy until the following cycle.
- With BYPASS=0, reads return pre-edge contents. o_RdBusy still equals busy[a], so a write and a read of the same address in one cycle shows busy=1 if the bit was set.
- Read ports are fully independent. Any ports may share an address and then return identical data.

## Timing
- Reset (async, i_Rst=1): all registers clear to 0 and all busy bits clear to 0 immediately, without waiting for a clock edge.
  - Hence o_BusyVec = 0, o_RdBusy = 0 and o_RdData = 0 for every port, except where a write is being bypassed.
  - Writes and issues are ignored while i_Rst=1.
  - A reset mid-operation discards all pending scoreboard entries.
- Release: the first rising edge after i_Rst falls performs normal writes and issues.
- Write latency: 1 edge to storage. With BYPASS=1 readers see the value 0 cycles after i_WrEn is presented.
- Issue latency: busy visible on o_BusyVec and o_RdBusy 1 cycle after i_IssueEn.
- No handshake: i_WrEn and i_IssueEn are single-cycle strobes accepted every cycle. Back-to-back writes to the same address keep the last value.
- Out-of-range slices cannot occur: the address width exactly covers the depth.

## Test plan
- Reset: write 0xDEADBEEF to r5, issue r7, then pulse i_Rst between edges. Required: r5 reads 0 and o_BusyVec=0 before the next edge.
- Write/read: write 0x12345678 to r3, then read r3 on ports 0 and 1 the next cycle. Required: both return 0x12345678 and o_RdBusy=00.
- Bypass: with BYPASS=1, in one cycle set i_WrEn=1, i_WrAddr=9, i_WrData=0xCAFEF00D and i_RdAddr port 1=9. Required: port 1 = 0xCAFEF00D that cycle.
  - With BYPASS=0, the same stimulus returns the old r9 value.
- Zero register: with ZERO_REG=1, write 0xFFFFFFFF to r0 and issue r0. Required: r0 reads 0, o_RdBusy=0 and o_BusyVec[0]=0.
  - With ZERO_REG=0, r0 reads 0xFFFFFFFF.
- Scoreboard: issue r4 (cycle 1), read r4 (cycle 2). Required: o_RdBusy=1.
  - Then write r4 with 0xA5 (cycle 3) while reading r4. Required: busy=0 and data 0xA5 via bypass.
- Simultaneous: issue r6 and write r6 in the same cycle. Required: data written, o_BusyVec[6]=1 the next cycle.
  - Then issue r2 and write r8 (with r8 previously busy) in the same cycle. Required: busy[2]=1 and busy[8]=0.
